// File: rtl/branch_resolver_pkg.sv
// Shared widths, prediction-queue entry layout and compare helpers for the branch resolver.
package branch_resolver_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;

  // Entry layout: {pred, predAddr, predPC}
  localparam int unsigned ENTRY_W  = 65;
  localparam int unsigned PRED_BIT = 64;
  localparam int unsigned ADDR_MSB = 63;
  localparam int unsigned ADDR_LSB = 32;
  localparam int unsigned PC_MSB   = 31;
  localparam int unsigned PC_LSB   = 0;

  typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;

  function automatic logic is_mispredict(input logic       pred,
                                         input inst_addr_t pred_addr,
                                         input logic       taken,
                                         input inst_addr_t target);
    return (taken != pred) || (taken && (target != pred_addr));
  endfunction

  function automatic inst_addr_t correct_pc(input logic       taken,
                                            input inst_addr_t target,
                                            input inst_addr_t pc);
    return taken ? target : pc + inst_addr_t'(4);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Predictor/fetch and branch-execute signals seen by the branch resolver.
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic       rdy;
  logic       predOutEn;
  logic       pred;
  inst_addr_t predAddr;
  inst_addr_t predPC;
  logic       qFull;
  logic       exEn;
  logic       exTaken;
  inst_addr_t exTarget;
  logic       BranchEn;
  logic       BranchMisTaken;
  inst_addr_t misTakenAddr;
  logic       clearEn;
  inst_addr_t clearAddr;
  logic [31:0] misCount;

  modport master (
    output rdy, predOutEn, pred, predAddr, predPC, exEn, exTaken, exTarget,
    input  qFull, BranchEn, BranchMisTaken, misTakenAddr, clearEn, clearAddr, misCount
  );

  modport slave (
    input  rdy, predOutEn, pred, predAddr, predPC, exEn, exTaken, exTarget,
    output qFull, BranchEn, BranchMisTaken, misTakenAddr, clearEn, clearAddr, misCount
  );

endinterface

// File: rtl/branch_resolver_pred_queue.sv
// In-order FIFO of in-flight predictions with a single-cycle flush.
module branch_resolver_pred_queue #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 65,
  parameter int unsigned IdxW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam logic [IdxW:0] DepthC = (IdxW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [IdxW-1:0]  head_q, tail_q;
  logic [IdxW:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DepthC);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[head_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_ok) tail_q <= tail_q + 1'b1;
        if (pop_ok)  head_q <= head_q + 1'b1;
        unique case ({push_ok, pop_ok})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage needs no reset: only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (!rst && en && push_ok && !flush) begin
      mem_q[tail_q] <= wdata;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Matches queued predictions against resolved branches; drives predictor update and redirect.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned QIDX   = 2
) (
  input logic               clk,
  input logic               rst,
  branch_resolver_if.slave  bus
);

  logic [ENTRY_W-1:0] head_entry;
  logic               q_full, q_empty;
  logic               resolve, mispred;
  inst_addr_t         head_pc, head_addr, fix_pc;

  logic        branch_en_q, mis_taken_q, clear_en_q;
  inst_addr_t  mis_addr_q, clear_addr_q;
  logic [31:0] mis_count_q;

  assign head_pc   = head_entry[PC_MSB:PC_LSB];
  assign head_addr = head_entry[ADDR_MSB:ADDR_LSB];
  assign resolve   = bus.rdy && bus.exEn && !q_empty;
  assign mispred   = is_mispredict(head_entry[PRED_BIT], head_addr, bus.exTaken, bus.exTarget);
  assign fix_pc    = correct_pc(bus.exTaken, bus.exTarget, head_pc);

  // A mispredict flush also discards any same-cycle push: it is wrong-path.
  branch_resolver_pred_queue #(
    .Depth (QDEPTH),
    .Width (ENTRY_W),
    .IdxW  (QIDX)
  ) u_pred_queue (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.rdy),
    .push  (bus.predOutEn),
    .pop   (resolve),
    .flush (resolve && mispred),
    .wdata ({bus.pred, bus.predAddr, bus.predPC}),
    .rdata (head_entry),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_en_q  <= 1'b0;
      mis_taken_q  <= 1'b0;
      clear_en_q   <= 1'b0;
      mis_addr_q   <= '0;
      clear_addr_q <= '0;
      mis_count_q  <= '0;
    end else if (bus.rdy) begin
      branch_en_q <= resolve;
      clear_en_q  <= resolve && mispred;
      if (resolve) begin
        mis_taken_q  <= mispred;
        mis_addr_q   <= head_pc;
        clear_addr_q <= fix_pc;
        if (mispred && (mis_count_q != '1)) mis_count_q <= mis_count_q + 32'd1;
      end
    end
  end

  assign bus.qFull          = q_full;
  assign bus.BranchEn       = branch_en_q;
  assign bus.BranchMisTaken = mis_taken_q;
  assign bus.misTakenAddr   = mis_addr_q;
  assign bus.clearEn        = clear_en_q;
  assign bus.clearAddr      = clear_addr_q;
  assign bus.misCount       = mis_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a prediction model and result scoreboard.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if bus ();

  branch_resolver #(
    .QDEPTH (4),
    .QIDX   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        p;
    logic [31:0] a;
    logic [31:0] pc;
  } pred_t;

  typedef struct {
    logic        mis;
    logic [31:0] pc;
    logic [31:0] caddr;
  } res_t;

  pred_t mq[$];
  res_t  sb[$];

  int checks = 0;
  int errors = 0;

  logic        e_ben, e_mis, e_clr;
  logic [31:0] e_maddr, e_caddr, e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("BranchEn", {31'b0, bus.BranchEn}, {31'b0, e_ben});
    check("BranchMisTaken", {31'b0, bus.BranchMisTaken}, {31'b0, e_mis});
    check("misTakenAddr", bus.misTakenAddr, e_maddr);
    check("clearEn", {31'b0, bus.clearEn}, {31'b0, e_clr});
    check("clearAddr", bus.clearAddr, e_caddr);
    check("misCount", bus.misCount, e_cnt);
  endtask

  task automatic drive_idle();
    bus.rdy       = 1'b1;
    bus.predOutEn = 1'b0;
    bus.pred      = 1'b0;
    bus.predAddr  = '0;
    bus.predPC    = '0;
    bus.exEn      = 1'b0;
    bus.exTaken   = 1'b0;
    bus.exTarget  = '0;
  endtask

  task automatic do_reset(input logic ex_during);
    drive_idle();
    bus.exEn    = ex_during;
    bus.exTaken = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    mq.delete();
    sb.delete();
    e_ben = 0; e_mis = 0; e_clr = 0;
    e_maddr = '0; e_caddr = '0; e_cnt = '0;
    check("qFull_after_reset", {31'b0, bus.qFull}, 32'd0);
    check_outputs();
  endtask

  // One clock of stimulus; model predicts the registered outputs after the edge.
  task automatic step(input logic ren, input logic pe, input logic p,
                      input logic [31:0] pa, input logic [31:0] pc,
                      input logic xe, input logic xt, input logic [31:0] xg);
    logic        full_now, resolving, mis;
    logic [31:0] corr;
    pred_t       h, n;
    res_t        r;
    bus.rdy = ren; bus.predOutEn = pe; bus.pred = p; bus.predAddr = pa; bus.predPC = pc;
    bus.exEn = xe; bus.exTaken = xt; bus.exTarget = xg;
    full_now = (mq.size() == 4);
    check("qFull", {31'b0, bus.qFull}, {31'b0, full_now});
    resolving = 1'b0;
    mis       = 1'b0;
    if (ren) begin
      if (xe && mq.size() != 0) begin
        resolving = 1'b1;
        h    = mq.pop_front();
        mis  = (xt != h.p) || (xt && (xg != h.a));
        corr = xt ? xg : h.pc + 32'd4;
        sb.push_back('{mis, h.pc, corr});
      end
      if (mis) mq.delete();
      else if (pe && !full_now) begin
        n = '{p, pa, pc};
        mq.push_back(n);
      end
      if (mis && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    drive_idle();
    if (ren) begin
      if (resolving) begin
        r = sb.pop_front();
        e_ben = 1'b1; e_mis = r.mis; e_maddr = r.pc; e_clr = r.mis; e_caddr = r.caddr;
      end else begin
        e_ben = 1'b0;
        e_clr = 1'b0;
      end
    end
    check_outputs();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic enq(input logic p, input logic [31:0] pa, input logic [31:0] pc);
    step(1'b1, 1'b1, p, pa, pc, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic res(input logic xt, input logic [31:0] xg);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, xt, xg);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();

    // Reset, idle, exEn on empty queue
    do_reset(1'b0);
    idle();
    res(1'b1, 32'h0000_0050);

    // Correct not-taken prediction
    enq(1'b0, 32'h104, 32'h100);
    res(1'b0, 32'h0);

    // Direction mispredict
    enq(1'b0, 32'h204, 32'h200);
    res(1'b1, 32'h240);

    // Target mispredict, then predicted-taken resolved not-taken
    enq(1'b1, 32'h300, 32'h2F0);
    res(1'b1, 32'h310);
    enq(1'b1, 32'h500, 32'h400);
    res(1'b0, 32'h0);

    // Fill, drop a 5th, then mispredict with a same-cycle enqueue
    enq(1'b0, 32'h1004, 32'h1000);
    enq(1'b0, 32'h1104, 32'h1100);
    enq(1'b0, 32'h1204, 32'h1200);
    enq(1'b0, 32'h1304, 32'h1300);
    enq(1'b0, 32'h1404, 32'h1400);
    idle();
    step(1'b1, 1'b1, 1'b1, 32'h2000, 32'h1F00, 1'b1, 1'b1, 32'h1800);
    idle();
    res(1'b0, 32'h0);

    // Simultaneous enqueue and correct resolve
    enq(1'b1, 32'h600, 32'h5F0);
    step(1'b1, 1'b1, 1'b0, 32'h704, 32'h700, 1'b1, 1'b1, 32'h600);
    res(1'b0, 32'h0);

    // rdy low holds outputs and pointers across exEn
    enq(1'b0, 32'h804, 32'h800);
    enq(1'b0, 32'h904, 32'h900);
    res(1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'hA00, 32'hA00, 1'b1, 1'b1, 32'hB00);
    res(1'b0, 32'h0);
    idle();

    // Reset with entries queued and a resolution in flight
    enq(1'b0, 32'hC04, 32'hC00);
    enq(1'b1, 32'hD40, 32'hD00);
    enq(1'b0, 32'hE04, 32'hE00);
    do_reset(1'b1);
    idle();
    res(1'b1, 32'hF00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
Closes the prediction loop for the branch predictor. It queues each prediction the predictor emits (direction, target, branch PC) in program order, then compares the head entry against the resolved outcome from the branch ALU. It produces the predictor's update strobe (BranchEn / BranchMisTaken / misTakenAddr) and a pipeline redirect on a mispredict. It sits between the predictor / fetch output and the branch execute stage.

Parameters:
QDEPTH, 4, in-flight prediction queue depth (power of two, >= 2)
QIDX, 2, log2(QDEPTH), queue pointer width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when 0 all state and outputs hold
predOutEn  in  1  prediction valid this cycle
pred  in  1  predicted direction (1 = taken)
predAddr  in  32  predicted next PC
predPC  in  32  PC of the predicted branch
qFull  out  1  queue full; the upstream stage must not assert predOutEn
exEn  in  1  branch resolved this cycle (in program order)
exTaken  in  1  actual direction
exTarget  in  32  actual taken target
BranchEn  out  1  one-cycle update strobe to the predictor
BranchMisTaken  out  1  qualified by BranchEn; 1 = mispredicted
misTakenAddr  out  32  PC of the resolved branch (predictor table index source)
clearEn  out  1  one-cycle redirect / flush strobe
clearAddr  out  32  correct next PC when clearEn = 1
misCount  out  32  saturating count of mispredicts since reset

Behaviour:
- Reset (rst = 1 at clk edge): head = tail = 0, count = 0; BranchEn, BranchMisTaken, clearEn = 0; misTakenAddr, clearAddr, misCount = 0. Reset overrides everything, including a resolution in flight.
- rdy = 0: no enqueue, no dequeue, outputs hold their current values.
- qFull is combinational: (count == QDEPTH).
- Enqueue: predOutEn && !qFull. Write {pred, predAddr, predPC} at tail, then tail += 1 (wraps mod QDEPTH).
- predOutEn while full: the entry is dropped silently. The verification engineer flags this as a protocol error.
- Resolve: exEn && count != 0. Read the head entry, then head += 1.
- Mispredict condition: (exTaken != pred) || (exTaken && exTarget != predAddr).
- Correct PC: exTaken ? exTarget : predPC + 4 (32-bit wrap).
- Outputs are registered, one cycle after the exEn edge:
  - BranchEn = 1.
  - BranchMisTaken = mispredict condition.
  - misTakenAddr = head predPC.
  - clearEn = mispredict condition.
  - clearAddr = correct PC.
- On a non-resolving cycle, BranchEn and clearEn return to 0. misTakenAddr and clearAddr hold their values.
- Mispredict flush: the same edge that dequeues the mispredicted head also empties the queue (head = tail = 0, count = 0). Any enqueue in that cycle is discarded, because it is a wrong-path prediction.
- exEn with count == 0: ignored. No strobe and no state change.
- Simultaneous enqueue and correct resolve: count is unchanged and both pointers advance. With the queue full, a resolve frees a slot only on the next cycle (qFull is based on the current count).
- misCount increments on each mispredict and saturates at 0xFFFFFFFF.

Decomposition:
- Shared defines file: the existing InstAddrBus width macro, plus the entry layout constants ENTRY_W = 65, PRED_BIT = 64, ADDR_MSB/LSB and PC_MSB/LSB.
- One sub-module, pred_queue: a generic FIFO with flush, exposing push/pop/full/empty/head data. branch_resolver contains the compare, redirect registers and counter.

Test Plan:
1. Reset, then idle: all outputs 0 and qFull = 0. An exEn pulse on the empty queue produces no BranchEn.
2. Enqueue (pred = 0, predAddr = 0x104, predPC = 0x100), then exEn with exTaken = 0: next cycle BranchEn = 1, BranchMisTaken = 0, misTakenAddr = 0x100, clearEn = 0.
3. Enqueue (pred = 0, predPC = 0x200), then exTaken = 1, exTarget = 0x240: BranchMisTaken = 1, clearEn = 1, clearAddr = 0x240, misCount = 1.
4. Enqueue (pred = 1, predAddr = 0x300, predPC = 0x2F0), then exTaken = 1, exTarget = 0x310 (target mismatch): clearAddr = 0x310. Enqueue (pred = 1, predPC = 0x400), then exTaken = 0: clearAddr = 0x404.
5. Fill 4 entries: qFull = 1 and a 5th predOutEn is dropped. Resolve the head as a mispredict while enqueueing in the same cycle: queue empties, qFull = 0, and the next exEn produces no strobe.
6. Hold rdy = 0 across an exEn pulse: no strobe and pointers unchanged. Assert rst with 3 entries queued: queue empty and all outputs 0 the next cycle.
